mw_stage_ext: RTL
=================

Name: mw_stage_ext

Overview:
- M→W pipeline register of the P6 five-stage MIPS core. It sits directly downstream of the M-stage memory check and consumes the raw data-memory word.
- Latches all M-stage results on each clock edge.
- In W, aligns and sign/zero-extends load data and selects the final register-file write data.
- Flags misaligned loads and suppresses their register write.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into W_PC on reset or flush.
- DW, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- M_stall  in  1  hold the W register contents this cycle
- M_flush  in  1  load a bubble into W this cycle
- M_PC  in  32  instruction address in M
- M_Instr  in  32  instruction word in M
- M_ALUout  in  32  ALU result; also the memory address
- M_Rdata  in  32  raw word read from DM, word-aligned
- M_HILO  in  32  HI/LO read value
- M_LoadOp  in  3  load type: 0 LW, 1 LBU, 2 LB, 3 LHU, 4 LH, 5–7 none
- M_WDSel  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+8, 3 HILO
- M_RegWrite  in  1  instruction writes the GRF
- M_A3  in  5  destination register
- W_PC  out  32  registered PC
- W_Instr  out  32  registered instruction
- W_A3  out  5  destination register; 0 when the write is suppressed
- W_RegWrite  out  1  final GRF write enable
- W_WD  out  32  final GRF write data
- W_AlignErr  out  1  misaligned load in W
- W_valid  out  1  W holds a real instruction, not a bubble

Behaviour:
- All state updates happen on the rising edge of clk.
- Priority: reset > M_flush > M_stall > normal capture.
- Reset and flush:
  - All registered fields go to 0, W_PC goes to RESET_PC, and W_valid goes to 0.
  - Therefore W_RegWrite=0, W_WD=0, W_AlignErr=0, W_A3=0 in the following cycle.
- Stall: every registered field holds. Outputs stay stable and are recomputed from the held fields.
- Normal capture: latch M_PC, M_Instr, M_ALUout, M_Rdata, M_HILO, M_LoadOp, M_WDSel, M_RegWrite, M_A3, and set W_valid=1.
- Latency: one cycle from M inputs to W outputs. Extension and selection are combinational on the registered fields. No combinational path from M inputs to outputs.
- Let off = registered ALUout[1:0].
- Load extension:
  - LW: the word as read.
  - LBU/LB: byte Rdata[8*off+7 : 8*off], zero- or sign-extended respectively.
  - LHU/LH: half Rdata[16*off[1]+15 : 16*off[1]], zero- or sign-extended respectively.
  - LoadOp 5–7: extended data = Rdata unchanged.
- Alignment check:
  - W_AlignErr=1 iff W_valid and either (LW and off≠0) or (LH/LHU and off[0]=1).
  - Byte loads never fault.
- Write-data select:
  - WDSel 0 → ALUout; 1 → extended data; 2 → PC+8 (mod 2^32); 3 → HILO.
- Write enable: W_RegWrite = W_valid & RegWrite & (A3≠0) & ~W_AlignErr.
- W_A3 = registered A3 when W_RegWrite=1, else 0. This keeps forwarding and hazard compares in other stages clean.
- W_WD is driven even when W_RegWrite=0; downstream ignores it.
- A reset asserted mid-stall clears the register; the stall is irrelevant on that edge.
- Stall and flush asserted together: the flush wins and a bubble is inserted.

Decomposition:
- Shared package / header holds:
  - LoadOp encodings: LD_LW, LD_LBU, LD_LB, LD_LHU, LD_LH, LD_NONE.
  - WDSel encodings: WD_ALU, WD_MEM, WD_PC8, WD_HILO.
  - RESET_PC default.
- One combinational sub-module, w_data_ext, with inputs (Rdata, off, LoadOp) and outputs (ExtData, AlignErr). Extension logic is unit-testable in isolation.
- mw_stage_ext owns the registers, the write-data mux, and the write-enable gating.

Test Plan:
- Reset, then capture LB with ALUout=0x0000_0003, Rdata=0x80FF_1234, WDSel=1, A3=8, RegWrite=1 → next cycle W_WD=0xFFFF_FF80, W_RegWrite=1, W_A3=8, W_AlignErr=0.
- LHU with ALUout=0x...2, Rdata=0xBEEF_0001 → W_WD=0x0000_BEEF. LH with off=1 → W_AlignErr=1, W_RegWrite=0, W_A3=0.
- LW with off=2 → W_AlignErr=1, no write. The same instruction with off=0 → W_WD=Rdata, W_RegWrite=1.
- JAL-type capture: M_PC=0x0000_3008, WDSel=2, A3=31 → W_WD=0x0000_3010. Then A3=0 with RegWrite=1 → W_RegWrite=0.
- Stall for 3 cycles after capturing ADD result 0x1234 while the M inputs change → W outputs constant at 0x1234. Release → new values appear one cycle later.
- Stall and flush asserted together → bubble: W_valid=0, W_RegWrite=0, W_PC=RESET_PC. Reset asserted during a stall → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/mw_stage_ext_pkg.sv
// Shared definitions for the M->W pipeline register and its load-extension
// unit: load-type and writeback-source encodings, datapath width, default
// reset PC.
package mw_stage_ext_pkg;

  localparam int          DW_DEFAULT       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Load type carried in LoadOp
  localparam logic [2:0] LD_LW   = 3'd0;
  localparam logic [2:0] LD_LBU  = 3'd1;
  localparam logic [2:0] LD_LB   = 3'd2;
  localparam logic [2:0] LD_LHU  = 3'd3;
  localparam logic [2:0] LD_LH   = 3'd4;
  localparam logic [2:0] LD_NONE = 3'd5;  // 5..7 all mean "not a load"

  // Writeback source carried in WDSel
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_PC8  = 2'd2;
  localparam logic [1:0] WD_HILO = 2'd3;

endpackage

// File: rtl/w_data_ext.sv
// Load data alignment and extension for the W stage (purely combinational).
// Ports:
//   Rdata    in  32  word read from data memory (word aligned)
//   off      in   2  byte offset within the word (address bits [1:0])
//   LoadOp   in   3  load type (LD_* encodings)
//   ExtData  out 32  aligned, zero/sign-extended load result
//   AlignErr out  1  access is misaligned for its size (not qualified by valid)
module w_data_ext
  import mw_stage_ext_pkg::*;
(
  input  logic [31:0] Rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  LoadOp,
  output logic [31:0] ExtData,
  output logic        AlignErr
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = Rdata[7:0];
      2'd1: byte_sel = Rdata[15:8];
      2'd2: byte_sel = Rdata[23:16];
      2'd3: byte_sel = Rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  // Only off[1] picks the half; off[0] only matters for the fault check.
  assign half_sel = off[1] ? Rdata[31:16] : Rdata[15:0];

  always_comb begin
    ExtData  = Rdata;
    AlignErr = 1'b0;
    case (LoadOp)
      LD_LW: begin
        ExtData  = Rdata;
        AlignErr = (off != 2'd0);
      end
      LD_LBU: ExtData = {24'h000000, byte_sel};
      LD_LB:  ExtData = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU: begin
        ExtData  = {16'h0000, half_sel};
        AlignErr = off[0];
      end
      LD_LH: begin
        ExtData  = {{16{half_sel[15]}}, half_sel};
        AlignErr = off[0];
      end
      default: begin
        ExtData  = Rdata;
        AlignErr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mw_stage_ext.sv
// M->W pipeline register with W-stage load extension and writeback select.
// Registers all M-stage results, then in W aligns/extends load data,
// picks the register-file write data and gates the write enable. Misaligned
// loads are flagged and never write the register file.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   M_stall, M_flush      hold W / insert a bubble into W (flush wins)
//   M_PC, M_Instr         instruction address and word in M
//   M_ALUout              ALU result, also the memory address
//   M_Rdata, M_HILO       raw DM word, HI/LO read value
//   M_LoadOp, M_WDSel     load type, writeback source
//   M_RegWrite, M_A3      register write request and destination
//   W_PC, W_Instr         registered PC and instruction
//   W_A3, W_RegWrite      final destination (0 if no write) and write enable
//   W_WD                  final write data (driven even when not writing)
//   W_AlignErr, W_valid   misaligned load in W, W holds a real instruction
module mw_stage_ext
  import mw_stage_ext_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DW       = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          M_stall,
  input  logic          M_flush,
  input  logic [DW-1:0] M_PC,
  input  logic [DW-1:0] M_Instr,
  input  logic [DW-1:0] M_ALUout,
  input  logic [DW-1:0] M_Rdata,
  input  logic [DW-1:0] M_HILO,
  input  logic [2:0]    M_LoadOp,
  input  logic [1:0]    M_WDSel,
  input  logic          M_RegWrite,
  input  logic [4:0]    M_A3,
  output logic [DW-1:0] W_PC,
  output logic [DW-1:0] W_Instr,
  output logic [4:0]    W_A3,
  output logic          W_RegWrite,
  output logic [DW-1:0] W_WD,
  output logic          W_AlignErr,
  output logic          W_valid
);

  logic [DW-1:0] pc_reg, instr_reg, alu_reg, rdata_reg, hilo_reg;
  logic [2:0]    loadop_reg;
  logic [1:0]    wdsel_reg;
  logic          regwrite_reg;
  logic [4:0]    a3_reg;
  logic          valid_reg;

  always_ff @(posedge clk) begin
    if (reset || M_flush) begin
      // Bubble: LoadOp 0 with valid 0 cannot fault, WDSel 0 with ALUout 0
      // makes W_WD read 0.
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      alu_reg      <= '0;
      rdata_reg    <= '0;
      hilo_reg     <= '0;
      loadop_reg   <= '0;
      wdsel_reg    <= '0;
      regwrite_reg <= 1'b0;
      a3_reg       <= '0;
      valid_reg    <= 1'b0;
    end else if (!M_stall) begin
      pc_reg       <= M_PC;
      instr_reg    <= M_Instr;
      alu_reg      <= M_ALUout;
      rdata_reg    <= M_Rdata;
      hilo_reg     <= M_HILO;
      loadop_reg   <= M_LoadOp;
      wdsel_reg    <= M_WDSel;
      regwrite_reg <= M_RegWrite;
      a3_reg       <= M_A3;
      valid_reg    <= 1'b1;
    end
  end

  logic [DW-1:0] ext_data;
  logic          ext_align_err;

  w_data_ext u_ext (
    .Rdata    (rdata_reg),
    .off      (alu_reg[1:0]),
    .LoadOp   (loadop_reg),
    .ExtData  (ext_data),
    .AlignErr (ext_align_err)
  );

  logic [DW-1:0] wd_next;

  always_comb begin
    wd_next = alu_reg;
    case (wdsel_reg)
      WD_ALU:  wd_next = alu_reg;
      WD_MEM:  wd_next = ext_data;
      WD_PC8:  wd_next = pc_reg + 32'd8;
      WD_HILO: wd_next = hilo_reg;
      default: wd_next = alu_reg;
    endcase
  end

  logic align_err, reg_write;

  assign align_err = valid_reg & ext_align_err;
  assign reg_write = valid_reg & regwrite_reg & (a3_reg != 5'd0) & ~align_err;

  assign W_PC       = pc_reg;
  assign W_Instr    = instr_reg;
  assign W_valid    = valid_reg;
  assign W_AlignErr = align_err;
  assign W_RegWrite = reg_write;
  // Zeroing A3 when not writing keeps forwarding/hazard compares clean.
  assign W_A3       = reg_write ? a3_reg : 5'd0;
  assign W_WD       = wd_next;

endmodule
